// File: rtl/nark_mem_pkg.sv
// Shared types and constants for the NARK memory-access stage.
package nark_mem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;

    localparam int unsigned MEM_TIMEOUT = 8;
    localparam int unsigned REG_ADDR_W  = 4;

    // Counter must be able to hold TIMEOUT itself.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int unsigned MEM_CNT_W = cnt_width(MEM_TIMEOUT);

endpackage

// File: rtl/memory_access_stage_if.sv
// Execute-side bundle, data-memory bus and write-back bundle of the memory stage.
interface memory_access_stage_if #(parameter int unsigned BITS = 24);
    import nark_mem_pkg::*;

    logic                  ValidE;
    logic [BITS-1:0]       ALUResultE;
    logic [BITS-1:0]       WriteDataE;
    logic [REG_ADDR_W-1:0] WA4E;
    logic                  RegWriteE;
    logic                  MemtoRegE;
    logic                  MemWriteE;
    logic                  StallM;

    logic                  MemReq;
    logic                  MemWe;
    logic [BITS-1:0]       MemAddr;
    logic [BITS-1:0]       MemWData;
    logic [BITS-1:0]       MemRData;
    logic                  MemAck;

    logic                  ValidW;
    logic                  RegWriteW;
    logic                  MemtoRegW;
    logic                  MemErrW;
    logic [BITS-1:0]       ALUResultW;
    logic [BITS-1:0]       ReadDataW;
    logic [REG_ADDR_W-1:0] WA4W;

    modport master (
        input  ValidE, ALUResultE, WriteDataE, WA4E, RegWriteE, MemtoRegE, MemWriteE,
        input  MemRData, MemAck,
        output StallM, MemReq, MemWe, MemAddr, MemWData,
        output ValidW, RegWriteW, MemtoRegW, MemErrW, ALUResultW, ReadDataW, WA4W
    );

    modport slave (
        output ValidE, ALUResultE, WriteDataE, WA4E, RegWriteE, MemtoRegE, MemWriteE,
        output MemRData, MemAck,
        input  StallM, MemReq, MemWe, MemAddr, MemWData,
        input  ValidW, RegWriteW, MemtoRegW, MemErrW, ALUResultW, ReadDataW, WA4W
    );

endinterface

// File: rtl/mem_wb_register.sv
// Load-enabled pipeline register for the write-back bank.
module mem_wb_register #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// NARK memory stage: req/ack transaction to data memory with timeout, then a registered W bundle.
module memory_access_stage
    import nark_mem_pkg::*;
#(
    parameter int unsigned BITS    = 24,
    parameter int unsigned TIMEOUT = MEM_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  RST,
    memory_access_stage_if.master bus
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);
    localparam int unsigned WB_W  = 2 + REG_ADDR_W + 2 * BITS;

    mem_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [BITS-1:0]       req_addr;
    logic [BITS-1:0]       req_wdata;
    logic [BITS-1:0]       rdata;
    logic [REG_ADDR_W-1:0] req_wa;
    logic                  req_rw;
    logic                  req_load;
    logic                  req_we;
    logic                  err;

    logic                  mem_op;
    logic                  wb_load;
    logic [WB_W-1:0]       wb_d;
    logic [WB_W-1:0]       wb_q;
    logic [1:0]            flags_d;
    logic [1:0]            flags_q;

    assign mem_op = bus.ValidE & (bus.MemtoRegE | bus.MemWriteE);

    // Transaction FSM with request registers and timeout counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            rdata     <= '0;
            req_wa    <= '0;
            req_rw    <= 1'b0;
            req_load  <= 1'b0;
            req_we    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        req_addr  <= bus.ALUResultE;
                        req_wdata <= bus.WriteDataE;
                        req_wa    <= bus.WA4E;
                        req_rw    <= bus.RegWriteE;
                        // Load+store together behaves as a plain store.
                        req_load  <= bus.MemtoRegE & ~bus.MemWriteE;
                        req_we    <= bus.MemWriteE;
                        rdata     <= '0;
                        cnt       <= '0;
                        err       <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.MemAck) begin
                        rdata <= req_load ? bus.MemRData : '0;
                        state <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // W-bank next values; the E bundle seen in DONE is the finished op and is dropped.
    always_comb begin
        wb_load = 1'b0;
        wb_d    = '0;
        flags_d = 2'b00;
        case (state)
            IDLE: begin
                flags_d = {bus.ValidE & ~mem_op, 1'b0};
                if (bus.ValidE && !mem_op) begin
                    wb_load = 1'b1;
                    wb_d    = {bus.RegWriteE, bus.MemtoRegE, bus.WA4E, bus.ALUResultE, {BITS{1'b0}}};
                end
            end
            DONE: begin
                flags_d = {1'b1, err};
                wb_load = 1'b1;
                wb_d    = {req_rw & ~err, req_load, req_wa, req_addr, rdata};
            end
            default: begin
                flags_d = 2'b00;
            end
        endcase
    end

    mem_wb_register #(.WIDTH(WB_W)) u_wb_data (
        .clk  (CLK),
        .rst  (RST),
        .load (wb_load),
        .d    (wb_d),
        .q    (wb_q)
    );

    mem_wb_register #(.WIDTH(2)) u_wb_flags (
        .clk  (CLK),
        .rst  (RST),
        .load (1'b1),
        .d    (flags_d),
        .q    (flags_q)
    );

    assign {bus.RegWriteW, bus.MemtoRegW, bus.WA4W, bus.ALUResultW, bus.ReadDataW} = wb_q;
    assign {bus.ValidW, bus.MemErrW} = flags_q;

    // Stall is needed in the same cycle a memory op arrives.
    assign bus.StallM   = ~RST & (((state == IDLE) & mem_op) | (state == REQ));
    assign bus.MemReq   = (state == REQ);
    assign bus.MemWe    = (state == REQ) & req_we;
    assign bus.MemAddr  = req_addr;
    assign bus.MemWData = req_wdata;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: table of ALU ops plus hand-written memory sequences.
module tb_memory_access_stage;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    memory_access_stage_if #(.BITS(24)) bus ();

    memory_access_stage #(.BITS(24), .TIMEOUT(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [23:0] alu;
        logic [3:0]  wa;
        logic        rw;
        logic        exp_valid;
        logic [23:0] exp_alu;
        logic [3:0]  exp_wa;
        logic        exp_rw;
    } alu_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_e(input logic v, input logic [23:0] alu, input logic [23:0] wd,
                           input logic [3:0] wa, input logic rw, input logic ld, input logic st);
        bus.ValidE     = v;
        bus.ALUResultE = alu;
        bus.WriteDataE = wd;
        bus.WA4E       = wa;
        bus.RegWriteE  = rw;
        bus.MemtoRegE  = ld;
        bus.MemWriteE  = st;
    endtask

    // k = ack cycle within REQ (1-based); k = 0 means memory never acks.
    task automatic mem_txn(input string tag, input logic ld, input logic st,
                           input logic [23:0] addr, input logic [23:0] wd, input logic [23:0] rd,
                           input logic [3:0] wa, input logic rw, input int k);
        logic        exp_err;
        int          exp_req;
        logic [23:0] exp_rd;
        int          req_cycles;
        int          stall_cycles;
        int          we_cycles;
        logic        unstable;
        logic        done;

        exp_err = (k == 0);
        exp_req = exp_err ? 8 : k;
        exp_rd  = (ld && !st && !exp_err) ? rd : 24'h0;

        drive_e(1'b1, addr, wd, wa, rw, ld, st);
        bus.MemAck = 1'b0;
        #1;
        chk({tag, "_stall_t"}, 32'(bus.StallM), 32'd1);
        chk({tag, "_req_t"}, 32'(bus.MemReq), 32'd0);
        tick();

        req_cycles   = 0;
        stall_cycles = 1;
        we_cycles    = 0;
        unstable     = 1'b0;
        done         = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            bus.MemAck   = (c == k);
            bus.MemRData = (c == k) ? rd : ~rd;
            #1;
            if (!bus.MemReq) begin
                done = 1'b1;
                break;
            end
            req_cycles++;
            if (bus.StallM) stall_cycles++;
            if (bus.MemWe) we_cycles++;
            if (bus.MemAddr !== addr || bus.MemWData !== wd || bus.MemWe !== st) unstable = 1'b1;
            tick();
        end
        bus.MemAck = 1'b0;
        chk({tag, "_finished"}, 32'(done), 32'd1);
        chk({tag, "_req_cycles"}, 32'(req_cycles), 32'(exp_req));
        chk({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_req + 1));
        chk({tag, "_we_cycles"}, 32'(we_cycles), st ? 32'(exp_req) : 32'd0);
        chk({tag, "_bus_stable"}, 32'(unstable), 32'd0);
        chk({tag, "_done_stall"}, 32'(bus.StallM), 32'd0);
        chk({tag, "_done_validw"}, 32'(bus.ValidW), 32'd0);

        tick();
        drive_e(1'b0, 24'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk({tag, "_no_reissue"}, 32'(bus.MemReq), 32'd0);
        chk({tag, "_w_valid"}, 32'(bus.ValidW), 32'd1);
        chk({tag, "_w_err"}, 32'(bus.MemErrW), 32'(exp_err));
        chk({tag, "_w_regwrite"}, 32'(bus.RegWriteW), 32'(rw & ~exp_err));
        chk({tag, "_w_memtoreg"}, 32'(bus.MemtoRegW), 32'(ld & ~st));
        chk({tag, "_w_rdata"}, 32'(bus.ReadDataW), 32'(exp_rd));
        chk({tag, "_w_alu"}, 32'(bus.ALUResultW), 32'(addr));
        chk({tag, "_w_wa"}, 32'(bus.WA4W), 32'(wa));

        tick();
        chk({tag, "_w_valid_pulse"}, 32'(bus.ValidW), 32'd0);
        chk({tag, "_w_err_pulse"}, 32'(bus.MemErrW), 32'd0);
    endtask

    alu_vec_t vecs [5];

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{1'b1, 24'h00ABCD, 4'd3,  1'b1, 1'b1, 24'h00ABCD, 4'd3,  1'b1};
        vecs[1] = '{1'b1, 24'h123456, 4'd15, 1'b0, 1'b1, 24'h123456, 4'd15, 1'b0};
        vecs[2] = '{1'b0, 24'hFFFFFF, 4'd7,  1'b1, 1'b0, 24'h123456, 4'd15, 1'b0};
        vecs[3] = '{1'b1, 24'h000000, 4'd0,  1'b1, 1'b1, 24'h000000, 4'd0,  1'b1};
        vecs[4] = '{1'b1, 24'hFFFFFF, 4'd9,  1'b1, 1'b1, 24'hFFFFFF, 4'd9,  1'b1};

        // Reset with a live load on E: everything must read zero.
        rst = 1'b1;
        drive_e(1'b1, 24'h000111, 24'h000222, 4'd1, 1'b1, 1'b1, 1'b0);
        bus.MemAck   = 1'b0;
        bus.MemRData = 24'h0;
        tick();
        tick();
        chk("rst_stall", 32'(bus.StallM), 32'd0);
        chk("rst_req", 32'(bus.MemReq), 32'd0);
        chk("rst_validw", 32'(bus.ValidW), 32'd0);
        chk("rst_wbank", 32'({bus.RegWriteW, bus.MemtoRegW, bus.MemErrW, bus.WA4W, bus.ALUResultW} != 0), 32'd0);
        chk("rst_addr", 32'(bus.MemAddr), 32'd0);
        drive_e(1'b0, 24'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Non-memory ops: one-cycle latency, never stall.
        for (int i = 0; i < 5; i++) begin
            drive_e(vecs[i].valid, vecs[i].alu, 24'h0, vecs[i].wa, vecs[i].rw, 1'b0, 1'b0);
            #1;
            chk($sformatf("alu%0d_stall", i), 32'(bus.StallM), 32'd0);
            tick();
            chk($sformatf("alu%0d_validw", i), 32'(bus.ValidW), 32'(vecs[i].exp_valid));
            chk($sformatf("alu%0d_alu", i), 32'(bus.ALUResultW), 32'(vecs[i].exp_alu));
            chk($sformatf("alu%0d_wa", i), 32'(bus.WA4W), 32'(vecs[i].exp_wa));
            chk($sformatf("alu%0d_rw", i), 32'(bus.RegWriteW), 32'(vecs[i].exp_rw));
            chk($sformatf("alu%0d_rdata", i), 32'(bus.ReadDataW), 32'd0);
            chk($sformatf("alu%0d_err", i), 32'(bus.MemErrW), 32'd0);
        end

        mem_txn("load_k3",  1'b1, 1'b0, 24'h000040, 24'h000000, 24'h123456, 4'd5, 1'b1, 3);
        mem_txn("store_k1", 1'b0, 1'b1, 24'h000080, 24'hFFFFFF, 24'h654321, 4'd6, 1'b0, 1);
        mem_txn("timeout",  1'b1, 1'b0, 24'h000100, 24'h000000, 24'h0BEEF0, 4'd7, 1'b1, 0);

        // Stray ack while idle must not start anything.
        drive_e(1'b0, 24'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        bus.MemAck   = 1'b1;
        bus.MemRData = 24'h999999;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stray%0d_req", i), 32'(bus.MemReq), 32'd0);
            chk($sformatf("stray%0d_stall", i), 32'(bus.StallM), 32'd0);
            tick();
            chk($sformatf("stray%0d_validw", i), 32'(bus.ValidW), 32'd0);
        end
        bus.MemAck = 1'b0;

        mem_txn("ack_last", 1'b1, 1'b0, 24'h000200, 24'h000000, 24'hABCDEF, 4'd8, 1'b1, 8);
        mem_txn("illegal",  1'b1, 1'b1, 24'h000300, 24'h00C0DE, 24'h777777, 4'd9, 1'b1, 2);

        // Asynchronous reset in the middle of REQ.
        drive_e(1'b1, 24'h000400, 24'h0, 4'd10, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        chk("midrst_pre_req", 32'(bus.MemReq), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_req", 32'(bus.MemReq), 32'd0);
        chk("midrst_stall", 32'(bus.StallM), 32'd0);
        chk("midrst_we", 32'(bus.MemWe), 32'd0);
        chk("midrst_wbank", 32'({bus.ValidW, bus.RegWriteW, bus.MemtoRegW, bus.MemErrW, bus.WA4W} != 0), 32'd0);
        chk("midrst_walu", 32'(bus.ALUResultW), 32'd0);
        drive_e(1'b0, 24'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        tick();
        chk("postrst_idle", 32'(bus.MemReq), 32'd0);
        drive_e(1'b1, 24'h0A0B0C, 24'h0, 4'd2, 1'b1, 1'b0, 1'b0);
        #1;
        chk("postrst_stall", 32'(bus.StallM), 32'd0);
        tick();
        chk("postrst_validw", 32'(bus.ValidW), 32'd1);
        chk("postrst_alu", 32'(bus.ALUResultW), 32'h0A0B0C);
        drive_e(1'b0, 24'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
